// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
//
// Shared types and constants for the architectural register file and its
// operand resolver.
//   ROB_WIDTH_BIT_DFLT : default ROB index width (mirrors the core-wide value)
//   REG_COUNT_DFLT     : default number of architectural registers
//   REG_IDX_W / XLEN   : register index width and data width
//   operand_src_e      : where a resolved source operand comes from
//   idx_in_range()     : bounds check for a register index
// ---------------------------------------------------------------------------
package register_file_pkg;

    localparam int ROB_WIDTH_BIT_DFLT = 5;
    localparam int REG_COUNT_DFLT     = 32;
    localparam int REG_IDX_W          = 5;
    localparam int XLEN               = 32;

    // Resolution source, listed in decreasing priority.
    typedef enum logic [2:0] {
        SRC_ZERO    = 3'd0,  // x0 (or an index beyond REG_COUNT)
        SRC_ARCH    = 3'd1,  // register not busy: architectural value
        SRC_COMMIT  = 3'd2,  // producer is committing this very cycle
        SRC_ROB     = 3'd3,  // producer finished, value held in the ROB
        SRC_PENDING = 3'd4   // producer still in flight
    } operand_src_e;

    // True when idx addresses a physically present register.
    function automatic logic idx_in_range(input logic [REG_IDX_W-1:0] idx,
                                          input int reg_count);
        return int'(idx) < reg_count;
    endfunction

endpackage : register_file_pkg

// File: rtl/register_file_port.sv
// ---------------------------------------------------------------------------
// register_file_port
//
// Combinational resolver for one source operand. Given the stored state of
// the addressed register, the commit stream and the ROB response, it
// produces either a value or a pending ROB tag.
//
// Ports:
//   rs_idx        in   source register index
//   reg_val       in   stored architectural value of rs_idx
//   reg_busy      in   busy bit of rs_idx
//   reg_tag       in   rename tag of rs_idx
//   commit_en     in   a commit is being accepted this cycle
//   write_reg_id  in   committing register
//   write_val     in   committing value
//   write_rob_id  in   committing ROB entry
//   rob_ready     in   ROB says the queried entry has its result
//   rob_val       in   ROB result for the queried entry
//   rob_id        out  tag sent to the ROB (0 when the register is idle)
//   has_dep       out  operand still pending
//   dep           out  pending tag (0 when no dependency)
//   val           out  operand value (0 while has_dep is high)
// ---------------------------------------------------------------------------
module register_file_port
    import register_file_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DFLT
) (
    input  logic [4:0]               rs_idx,
    input  logic [31:0]              reg_val,
    input  logic                     reg_busy,
    input  logic [ROB_WIDTH_BIT-1:0] reg_tag,
    input  logic                     commit_en,
    input  logic [4:0]               write_reg_id,
    input  logic [31:0]              write_val,
    input  logic [ROB_WIDTH_BIT-1:0] write_rob_id,
    input  logic                     rob_ready,
    input  logic [31:0]              rob_val,
    output logic [ROB_WIDTH_BIT-1:0] rob_id,
    output logic                     has_dep,
    output logic [ROB_WIDTH_BIT-1:0] dep,
    output logic [31:0]              val
);

    operand_src_e src;
    logic         commit_hit;

    // A commit only bypasses when it retires exactly the producer this
    // register is waiting for; an older producer of the same register
    // does not satisfy the dependency.
    assign commit_hit = commit_en
                      && (write_reg_id == rs_idx)
                      && (write_rob_id == reg_tag);

    // The ROB query is masked so an idle register never presents a stale tag.
    assign rob_id = (reg_busy && (rs_idx != '0)) ? reg_tag : '0;

    always_comb begin
        src = SRC_PENDING;
        if (rs_idx == '0) begin
            src = SRC_ZERO;
        end else if (!reg_busy) begin
            src = SRC_ARCH;
        end else if (commit_hit) begin
            src = SRC_COMMIT;
        end else if (rob_ready) begin
            src = SRC_ROB;
        end
    end

    always_comb begin
        has_dep = 1'b0;
        dep     = '0;
        val     = '0;
        case (src)
            SRC_ZERO:    val = '0;
            SRC_ARCH:    val = reg_val;
            SRC_COMMIT:  val = write_val;
            SRC_ROB:     val = rob_val;
            SRC_PENDING: begin
                has_dep = 1'b1;
                dep     = reg_tag;
            end
            default: begin
                has_dep = 1'b0;
                dep     = '0;
                val     = '0;
            end
        endcase
    end

endmodule : register_file_port

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Architectural register file with rename tags. Dispatch marks a destination
// busy with its producing ROB entry, commit writes values and releases the
// tag, and a ROB clear drops every tag while keeping the values. Two source
// operands are resolved combinationally to a value or a pending tag.
//
// Ports:
//   clk_in, rst_in              clock, asynchronous active-high reset
//   rdy_in                      global enable; low freezes all state
//   clear_flag                  ROB misprediction flush
//   write_reg_id/val/ROB_id     commit stream (reg 0 = no commit)
//   new_reg_id/new_ROB_id       rename from dispatch (reg 0 = no rename)
//   dec_rs1/dec_rs2             source indices from the decoder
//   rob_rs1_id/rob_rs2_id       tags queried in the ROB
//   rob_rs1_ready/val, rob_rs2_ready/val   ROB responses
//   rs1_has_dep/dep/val, rs2_has_dep/dep/val  resolved operands
// ---------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DFLT,
    parameter int REG_COUNT     = REG_COUNT_DFLT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_flag,
    input  logic [4:0]               write_reg_id,
    input  logic [31:0]              write_val,
    input  logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
    input  logic [4:0]               new_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
    input  logic [4:0]               dec_rs1,
    input  logic [4:0]               dec_rs2,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
    input  logic                     rob_rs1_ready,
    input  logic                     rob_rs2_ready,
    input  logic [31:0]              rob_rs1_val,
    input  logic [31:0]              rob_rs2_val,
    output logic                     rs1_has_dep,
    output logic                     rs2_has_dep,
    output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
    output logic [ROB_WIDTH_BIT-1:0] rs2_dep,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val
);

    // -----------------------------------------------------------------------
    // Architectural state
    // -----------------------------------------------------------------------
    logic [31:0]              val_q  [REG_COUNT];
    logic [31:0]              val_d  [REG_COUNT];
    logic                     busy_q [REG_COUNT];
    logic                     busy_d [REG_COUNT];
    logic [ROB_WIDTH_BIT-1:0] tag_q  [REG_COUNT];
    logic [ROB_WIDTH_BIT-1:0] tag_d  [REG_COUNT];

    logic commit_en;
    logic rename_en;
    logic flush_en;

    assign commit_en = rdy_in && (write_reg_id != '0);
    // A rename issued alongside a flush belongs to the squashed path.
    assign rename_en = rdy_in && (new_reg_id != '0) && !clear_flag;
    assign flush_en  = rdy_in && clear_flag;

    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            val_d[i]  = val_q[i];
            busy_d[i] = busy_q[i];
            tag_d[i]  = tag_q[i];

            if (i != 0) begin
                if (commit_en && (write_reg_id == REG_IDX_W'(i))) begin
                    val_d[i] = write_val;
                    // Only the youngest producer may release the register;
                    // a same-cycle rename re-arms it below anyway.
                    if ((tag_q[i] == write_ROB_id)
                        && !(rename_en && (new_reg_id == REG_IDX_W'(i)))) begin
                        busy_d[i] = 1'b0;
                    end
                end
                if (rename_en && (new_reg_id == REG_IDX_W'(i))) begin
                    busy_d[i] = 1'b1;
                    tag_d[i]  = new_ROB_id;
                end
                if (flush_en) begin
                    busy_d[i] = 1'b0;
                    tag_d[i]  = '0;
                end
            end
        end
        // x0 is a constant zero that is never busy.
        val_d[0]  = '0;
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                val_q[i]  <= val_d[i];
                busy_q[i] <= busy_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Operand resolution: two identical read ports
    // -----------------------------------------------------------------------
    logic [4:0]               rs_idx    [2];
    logic                     rs_ready  [2];
    logic [31:0]              rs_rob    [2];
    logic [ROB_WIDTH_BIT-1:0] port_rid  [2];
    logic                     port_hdep [2];
    logic [ROB_WIDTH_BIT-1:0] port_dep  [2];
    logic [31:0]              port_val  [2];

    assign rs_idx[0]   = dec_rs1;
    assign rs_idx[1]   = dec_rs2;
    assign rs_ready[0] = rob_rs1_ready;
    assign rs_ready[1] = rob_rs2_ready;
    assign rs_rob[0]   = rob_rs1_val;
    assign rs_rob[1]   = rob_rs2_val;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0]              rd_val;
            logic                     rd_busy;
            logic [ROB_WIDTH_BIT-1:0] rd_tag;

            // Indices beyond REG_COUNT read as an idle zero register.
            always_comb begin
                rd_val  = '0;
                rd_busy = 1'b0;
                rd_tag  = '0;
                if (idx_in_range(rs_idx[gi], REG_COUNT)) begin
                    rd_val  = val_q[rs_idx[gi]];
                    rd_busy = busy_q[rs_idx[gi]];
                    rd_tag  = tag_q[rs_idx[gi]];
                end
            end

            register_file_port #(
                .ROB_WIDTH_BIT (ROB_WIDTH_BIT)
            ) u_port (
                .rs_idx       (rs_idx[gi]),
                .reg_val      (rd_val),
                .reg_busy     (rd_busy),
                .reg_tag      (rd_tag),
                .commit_en    (commit_en),
                .write_reg_id (write_reg_id),
                .write_val    (write_val),
                .write_rob_id (write_ROB_id),
                .rob_ready    (rs_ready[gi]),
                .rob_val      (rs_rob[gi]),
                .rob_id       (port_rid[gi]),
                .has_dep      (port_hdep[gi]),
                .dep          (port_dep[gi]),
                .val          (port_val[gi])
            );
        end
    endgenerate

    assign rob_rs1_id  = port_rid[0];
    assign rob_rs2_id  = port_rid[1];
    assign rs1_has_dep = port_hdep[0];
    assign rs2_has_dep = port_hdep[1];
    assign rs1_dep     = port_dep[0];
    assign rs2_dep     = port_dep[1];
    assign rs1_val     = port_val[0];
    assign rs2_val     = port_val[1];

endmodule : register_file

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int RW = 5;

    typedef struct {
        logic          rdy;
        logic          clr;
        logic [4:0]    wid;
        logic [31:0]   wval;
        logic [RW-1:0] wrob;
        logic [4:0]    nid;
        logic [RW-1:0] nrob;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic          r1rdy;
        logic [31:0]   r1val;
        logic          r2rdy;
        logic [31:0]   r2val;
    } in_t;

    typedef struct {
        logic          h;
        logic [RW-1:0] d;
        logic [31:0]   v;
        logic [RW-1:0] rid;
    } opexp_t;

    typedef struct {
        in_t    in;
        opexp_t e1;
        opexp_t e2;
    } vec_t;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear_flag;
    logic [4:0]    write_reg_id;
    logic [31:0]   write_val;
    logic [RW-1:0] write_ROB_id;
    logic [4:0]    new_reg_id;
    logic [RW-1:0] new_ROB_id;
    logic [4:0]    dec_rs1;
    logic [4:0]    dec_rs2;
    logic [RW-1:0] rob_rs1_id;
    logic [RW-1:0] rob_rs2_id;
    logic          rob_rs1_ready;
    logic          rob_rs2_ready;
    logic [31:0]   rob_rs1_val;
    logic [31:0]   rob_rs2_val;
    logic          rs1_has_dep;
    logic          rs2_has_dep;
    logic [RW-1:0] rs1_dep;
    logic [RW-1:0] rs2_dep;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;

    register_file #(
        .ROB_WIDTH_BIT (RW),
        .REG_COUNT     (32)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear_flag    (clear_flag),
        .write_reg_id  (write_reg_id),
        .write_val     (write_val),
        .write_ROB_id  (write_ROB_id),
        .new_reg_id    (new_reg_id),
        .new_ROB_id    (new_ROB_id),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .rob_rs1_id    (rob_rs1_id),
        .rob_rs2_id    (rob_rs2_id),
        .rob_rs1_ready (rob_rs1_ready),
        .rob_rs2_ready (rob_rs2_ready),
        .rob_rs1_val   (rob_rs1_val),
        .rob_rs2_val   (rob_rs2_val),
        .rs1_has_dep   (rs1_has_dep),
        .rs2_has_dep   (rs2_has_dep),
        .rs1_dep       (rs1_dep),
        .rs2_dep       (rs2_dep),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain per-register arrays.
    logic [31:0]   m_val  [32];
    bit            m_busy [32];
    logic [RW-1:0] m_tag  [32];
    in_t           cur;
    vec_t          tbl [$];

    function automatic in_t mk(input logic rdy, input logic clr,
                               input logic [4:0] wid, input logic [31:0] wval,
                               input logic [RW-1:0] wrob,
                               input logic [4:0] nid, input logic [RW-1:0] nrob,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic r1rdy, input logic [31:0] r1val,
                               input logic r2rdy, input logic [31:0] r2val);
        in_t v;
        v.rdy = rdy;   v.clr = clr;
        v.wid = wid;   v.wval = wval;  v.wrob = wrob;
        v.nid = nid;   v.nrob = nrob;
        v.rs1 = rs1;   v.rs2 = rs2;
        v.r1rdy = r1rdy; v.r1val = r1val;
        v.r2rdy = r2rdy; v.r2val = r2val;
        return v;
    endfunction

    function automatic opexp_t ex(input logic h, input logic [RW-1:0] d,
                                  input logic [31:0] v, input logic [RW-1:0] rid);
        opexp_t e;
        e.h = h; e.d = d; e.v = v; e.rid = rid;
        return e;
    endfunction

    task automatic add(input in_t v, input opexp_t e1, input opexp_t e2);
        vec_t t;
        t.in = v; t.e1 = e1; t.e2 = e2;
        tbl.push_back(t);
    endtask

    task automatic drive(input in_t v);
        cur           = v;
        rdy_in        = v.rdy;
        clear_flag    = v.clr;
        write_reg_id  = v.wid;
        write_val     = v.wval;
        write_ROB_id  = v.wrob;
        new_reg_id    = v.nid;
        new_ROB_id    = v.nrob;
        dec_rs1       = v.rs1;
        dec_rs2       = v.rs2;
        rob_rs1_ready = v.r1rdy;
        rob_rs1_val   = v.r1val;
        rob_rs2_ready = v.r2rdy;
        rob_rs2_val   = v.r2val;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ops(input string pfx, input opexp_t e1, input opexp_t e2);
        chk({pfx, " rs1_has_dep"}, 32'(rs1_has_dep), 32'(e1.h));
        chk({pfx, " rs1_dep"},     32'(rs1_dep),     32'(e1.d));
        chk({pfx, " rs1_val"},     rs1_val,          e1.v);
        chk({pfx, " rob_rs1_id"},  32'(rob_rs1_id),  32'(e1.rid));
        chk({pfx, " rs2_has_dep"}, 32'(rs2_has_dep), 32'(e2.h));
        chk({pfx, " rs2_dep"},     32'(rs2_dep),     32'(e2.d));
        chk({pfx, " rs2_val"},     rs2_val,          e2.v);
        chk({pfx, " rob_rs2_id"},  32'(rob_rs2_id),  32'(e2.rid));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
    endtask

    // State change at a clock edge, straight from the operation rules.
    task automatic model_update(input in_t v);
        bit ren;
        if (!v.rdy) return;
        ren = (v.nid != 0) && !v.clr;
        if (v.wid != 0) begin
            m_val[v.wid] = v.wval;
            if (m_tag[v.wid] == v.wrob && !(ren && v.nid == v.wid))
                m_busy[v.wid] = 1'b0;
        end
        if (ren) begin
            m_busy[v.nid] = 1'b1;
            m_tag[v.nid]  = v.nrob;
        end
        if (v.clr) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end
    endtask

    function automatic opexp_t model_res(input logic [4:0] r, input logic rr,
                                         input logic [31:0] rv, input in_t v);
        opexp_t e;
        e = ex(1'b0, '0, '0, '0);
        if (r == 0) return e;
        if (!m_busy[r]) begin
            e.v = m_val[r];
            return e;
        end
        e.rid = m_tag[r];
        if (v.rdy && v.wid == r && v.wrob == m_tag[r]) e.v = v.wval;
        else if (rr) e.v = rv;
        else begin
            e.h = 1'b1;
            e.d = m_tag[r];
        end
        return e;
    endfunction

    task automatic step_edge();
        @(posedge clk_in);
        if (!rst_in) model_update(cur);
    endtask

    initial begin
        in_t    idle;
        in_t    rv;
        opexp_t e1;
        opexp_t e2;

        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_in = 1'b1;
        drive(idle);
        model_reset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        //     rdy clr wid wval          wrob nid nrob rs1 rs2 r1rdy r1val     r2rdy r2val
        add(mk(1, 0,  0, 0,            0,  0,  0,  5,  7, 0, 0,          0, 0),
            ex(0, 0, 0, 0),            ex(0, 0, 0, 0));
        add(mk(1, 0,  5, 32'h1234,     3,  0,  0,  5,  0, 0, 0,          0, 0),
            ex(0, 0, 0, 0),            ex(0, 0, 0, 0));
        add(mk(1, 0,  0, 0,            0,  7,  4,  5,  7, 0, 0,          0, 0),
            ex(0, 0, 32'h1234, 0),     ex(0, 0, 0, 0));
        add(mk(1, 0,  0, 0,            0,  0,  0,  7,  7, 0, 0,          1, 32'hAB),
            ex(1, 4, 0, 4),            ex(0, 0, 32'hAB, 4));
        add(mk(1, 0,  0, 0,            0,  7,  9,  7,  5, 0, 0,          0, 0),
            ex(1, 4, 0, 4),            ex(0, 0, 32'h1234, 0));
        add(mk(1, 0,  7, 32'h11,       4,  0,  0,  7,  7, 0, 0,          1, 32'h55),
            ex(1, 9, 0, 9),            ex(0, 0, 32'h55, 9));
        add(mk(1, 0,  0, 0,            0,  3,  2,  7,  3, 0, 0,          0, 0),
            ex(1, 9, 0, 9),            ex(0, 0, 0, 0));
        add(mk(1, 0,  3, 32'h3333,     2,  3,  6,  3,  3, 0, 0,          1, 32'hDEAD),
            ex(0, 0, 32'h3333, 2),     ex(0, 0, 32'h3333, 2));
        add(mk(1, 0,  0, 0,            0,  1,  1,  3,  7, 0, 0,          0, 0),
            ex(1, 6, 0, 6),            ex(1, 9, 0, 9));
        add(mk(1, 0,  0, 0,            0,  2,  2,  1,  0, 0, 0,          0, 0),
            ex(1, 1, 0, 1),            ex(0, 0, 0, 0));
        add(mk(1, 0,  0, 0,            0, 10, 10,  2,  3, 0, 0,          0, 0),
            ex(1, 2, 0, 2),            ex(1, 6, 0, 6));
        add(mk(1, 1,  5, 32'h5555,     0,  4, 12, 10,  4, 0, 0,          0, 0),
            ex(1, 10, 0, 10),          ex(0, 0, 0, 0));
        add(mk(1, 0,  0, 0,            0,  0,  0,  7,  3, 0, 0,          0, 0),
            ex(0, 0, 32'h11, 0),       ex(0, 0, 32'h3333, 0));
        add(mk(1, 0,  0, 0,            0,  0,  0,  4,  5, 0, 0,          0, 0),
            ex(0, 0, 0, 0),            ex(0, 0, 32'h5555, 0));
        add(mk(1, 0,  0, 0,            0,  0,  0,  1, 10, 0, 0,          0, 0),
            ex(0, 0, 0, 0),            ex(0, 0, 0, 0));
        add(mk(1, 0,  0, 32'hFF,       0,  0,  7,  0,  0, 0, 0,          0, 0),
            ex(0, 0, 0, 0),            ex(0, 0, 0, 0));
        add(mk(1, 0,  0, 0,            0,  0,  0,  0,  0, 1, 32'h77,     1, 32'h88),
            ex(0, 0, 0, 0),            ex(0, 0, 0, 0));
        add(mk(0, 0,  5, 32'h9999,     0,  5,  3,  5,  7, 0, 0,          0, 0),
            ex(0, 0, 32'h5555, 0),     ex(0, 0, 32'h11, 0));
        add(mk(1, 0,  0, 0,            0,  0,  0,  5,  7, 0, 0,          0, 0),
            ex(0, 0, 32'h5555, 0),     ex(0, 0, 32'h11, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_in);
            drive(tbl[i].in);
            #1;
            check_ops($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2);
            $display("vec %0d: rs1=x%0d val=%08h dep=%0d/%0d | rs2=x%0d val=%08h dep=%0d/%0d",
                     i, dec_rs1, rs1_val, rs1_has_dep, rs1_dep,
                     dec_rs2, rs2_val, rs2_has_dep, rs2_dep);
            step_edge();
        end

        // Asynchronous reset between edges drops a pending tag at once.
        @(negedge clk_in);
        drive(mk(1, 0, 0, 0, 0, 9, 5, 0, 0, 0, 0, 0, 0));
        step_edge();
        @(negedge clk_in);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0));
        #1;
        chk("pre_reset rs1_has_dep", 32'(rs1_has_dep), 32'd1);
        chk("pre_reset rs1_dep",     32'(rs1_dep),     32'd5);
        #1;
        rst_in = 1'b1;
        #1;
        model_reset();
        chk("async_reset rs1_has_dep", 32'(rs1_has_dep), 32'd0);
        chk("async_reset rob_rs1_id",  32'(rob_rs1_id),  32'd0);
        chk("async_reset rs1_dep",     32'(rs1_dep),     32'd0);
        $display("async reset: rs1=x9 val=%08h dep=%0d/%0d rob_id=%0d",
                 rs1_val, rs1_has_dep, rs1_dep, rob_rs1_id);
        step_edge();
        @(negedge clk_in);
        rst_in = 1'b0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_in);
            rv.rdy   = ($urandom_range(0, 7) != 0);
            rv.clr   = ($urandom_range(0, 19) == 0);
            rv.wid   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
            rv.wval  = $urandom;
            rv.wrob  = ($urandom_range(0, 1) == 1) ? m_tag[rv.wid] : RW'($urandom);
            rv.nid   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
            rv.nrob  = RW'($urandom);
            rv.rs1   = 5'($urandom_range(0, 7));
            rv.rs2   = 5'($urandom_range(0, 7));
            rv.r1rdy = ($urandom_range(0, 2) == 0);
            rv.r1val = $urandom;
            rv.r2rdy = ($urandom_range(0, 2) == 0);
            rv.r2val = $urandom;
            drive(rv);
            #1;
            e1 = model_res(rv.rs1, rv.r1rdy, rv.r1val, rv);
            e2 = model_res(rv.rs2, rv.r2rdy, rv.r2val, rv);
            check_ops($sformatf("rnd%0d", c), e1, e2);
            $display("rnd %0d: rs1=x%0d val=%08h dep=%0d/%0d | rs2=x%0d val=%08h dep=%0d/%0d",
                     c, dec_rs1, rs1_val, rs1_has_dep, rs1_dep,
                     dec_rs2, rs2_val, rs2_has_dep, rs2_dep);
            step_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file
